// File: rtl/mips_core_pkg.sv
// Shared scheduler types and sizing constants.
//   DEPTH / IDX_W / TAG_W : queue depth, slot index width, register tag width
//   status_e              : per-entry lifecycle (not_ready -> ready -> executing -> done)
//   entry_t               : per-entry bookkeeping held by the issue scheduler
//   src_is_ready()        : operand readiness at allocation, including writeback bypass
package mips_core_pkg;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int TAG_W = 5;

    typedef enum logic [1:0] {
        ST_NOT_READY = 2'd0,
        ST_READY     = 2'd1,
        ST_EXECUTING = 2'd2,
        ST_DONE      = 2'd3
    } status_e;

    typedef struct packed {
        logic             valid;
        status_e          status;
        logic [TAG_W-1:0] src1_tag;
        logic [TAG_W-1:0] src2_tag;
        logic             src1_rdy;
        logic             src2_rdy;
    } entry_t;

    // Tag 0 is the hard-wired $zero register, so it never has to wait.
    function automatic logic src_is_ready(input logic             rdy,
                                          input logic [TAG_W-1:0] tag,
                                          input logic             wb_valid,
                                          input logic [TAG_W-1:0] wb_tag);
        return rdy || (tag == '0) || (wb_valid && (wb_tag == tag));
    endfunction

endpackage

// File: rtl/oldest_ready_select.sv
// Circular priority picker: returns the first set bit of ready_vec found
// when scanning upward from head (wrapping modulo DEPTH).
//   ready_vec : per-slot request bits
//   head      : oldest slot, highest priority
//   valid     : at least one request present
//   idx       : selected slot (equals head when nothing is selected)
module oldest_ready_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [DEPTH-1:0] ready_vec,
    input  logic [IDX_W-1:0] head,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = head;
        // Walk from the youngest position back to head so the oldest hit wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[head + IDX_W'(i)]) begin
                valid = 1'b1;
                idx   = head + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ooo_issue_scheduler.sv
// Out-of-order issue queue controller (status and pointers only; payload
// storage elsewhere is indexed by alloc_idx / issue_idx / retire_idx).
//   alloc_*    : decode-side allocation handshake and source operand info
//   wb_*       : register writeback broadcast used for wakeup and bypass
//   issue_*    : oldest-ready selection toward execute, with back-pressure
//   complete_* : execution-finished notification for an executing slot
//   retire_*   : in-order retirement of the head entry when done
//   flush      : discard every entry; outputs still show pre-flush state
//   occupancy  : number of live entries, 0..DEPTH
module ooo_issue_scheduler #(
    parameter int DEPTH = mips_core_pkg::DEPTH,
    parameter int IDX_W = mips_core_pkg::IDX_W,
    parameter int TAG_W = mips_core_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic [TAG_W-1:0] alloc_src1_tag,
    input  logic             alloc_src1_rdy,
    input  logic [TAG_W-1:0] alloc_src2_tag,
    input  logic             alloc_src2_rdy,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    output logic             issue_valid,
    output logic [IDX_W-1:0] issue_idx,
    input  logic             issue_ready,
    input  logic             complete_valid,
    input  logic [IDX_W-1:0] complete_idx,
    output logic             retire_valid,
    output logic [IDX_W-1:0] retire_idx,
    output logic [IDX_W:0]   occupancy
);

    import mips_core_pkg::*;

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    entry_t           q     [DEPTH];
    entry_t           q_nxt [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;
    logic [DEPTH-1:0] ready_vec;
    logic             do_alloc;
    logic             do_issue;
    logic             do_complete;
    logic             do_retire;
    logic             new_src1_rdy;
    logic             new_src2_rdy;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = q[i].valid && (q[i].status == ST_READY);
        end
    end

    oldest_ready_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .ready_vec (ready_vec),
        .head      (head),
        .valid     (issue_valid),
        .idx       (issue_idx)
    );

    // Reset forces alloc_ready low even though count is already zero.
    assign alloc_ready  = !rst && (count < FULL_CNT);
    assign alloc_idx    = tail;
    assign occupancy    = count;
    assign retire_valid = q[head].valid && (q[head].status == ST_DONE);
    assign retire_idx   = head;

    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_issue    = issue_valid && issue_ready;
    assign do_retire   = retire_valid;
    // Stale or bogus completions (slot not executing) are dropped silently.
    assign do_complete = complete_valid && q[complete_idx].valid &&
                         (q[complete_idx].status == ST_EXECUTING);

    assign new_src1_rdy = src_is_ready(alloc_src1_rdy, alloc_src1_tag, wb_valid, wb_tag);
    assign new_src2_rdy = src_is_ready(alloc_src2_rdy, alloc_src2_tag, wb_valid, wb_tag);

    // Issue, complete, retire and allocate always touch different slots
    // (ready / executing / done / free), so their updates never collide.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = q[i];
            if (q[i].valid) begin
                if (wb_valid && (wb_tag == q[i].src1_tag)) q_nxt[i].src1_rdy = 1'b1;
                if (wb_valid && (wb_tag == q[i].src2_tag)) q_nxt[i].src2_rdy = 1'b1;
                if ((q[i].status == ST_NOT_READY) && q_nxt[i].src1_rdy && q_nxt[i].src2_rdy)
                    q_nxt[i].status = ST_READY;
            end
        end
        if (do_issue)    q_nxt[issue_idx].status    = ST_EXECUTING;
        if (do_complete) q_nxt[complete_idx].status = ST_DONE;
        if (do_retire)   q_nxt[head]                = '0;
        if (do_alloc) begin
            q_nxt[tail].valid    = 1'b1;
            q_nxt[tail].src1_tag = alloc_src1_tag;
            q_nxt[tail].src2_tag = alloc_src2_tag;
            q_nxt[tail].src1_rdy = new_src1_rdy;
            q_nxt[tail].src2_rdy = new_src2_rdy;
            q_nxt[tail].status   = (new_src1_rdy && new_src2_rdy) ? ST_READY : ST_NOT_READY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            q     <= q_nxt;
            head  <= head + IDX_W'(do_retire);
            tail  <= tail + IDX_W'(do_alloc);
            count <= count + (IDX_W + 1)'(do_alloc) - (IDX_W + 1)'(do_retire);
        end
    end

endmodule

// File: tb/tb_ooo_issue_scheduler.sv
// Scoreboard bench for ooo_issue_scheduler: a program-order queue model
// predicts every cycle's outputs; a monitor compares them against the DUT.
module tb_ooo_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [2:0] alloc_idx;
    logic [4:0] alloc_src1_tag = '0;
    logic       alloc_src1_rdy = 1'b0;
    logic [4:0] alloc_src2_tag = '0;
    logic       alloc_src2_rdy = 1'b0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_tag = '0;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic       issue_ready = 1'b0;
    logic       complete_valid = 1'b0;
    logic [2:0] complete_idx = '0;
    logic       retire_valid;
    logic [2:0] retire_idx;
    logic [3:0] occupancy;

    always #5 clk = ~clk;

    ooo_issue_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_idx      (alloc_idx),
        .alloc_src1_tag (alloc_src1_tag),
        .alloc_src1_rdy (alloc_src1_rdy),
        .alloc_src2_tag (alloc_src2_tag),
        .alloc_src2_rdy (alloc_src2_rdy),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .issue_ready    (issue_ready),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .retire_valid   (retire_valid),
        .retire_idx     (retire_idx),
        .occupancy      (occupancy)
    );

    // Model: live instructions in program order; slot = (mhead + position) % 8.
    localparam int NR = 0, RD = 1, EX = 2, DN = 3;
    typedef struct { int st; bit r1; bit r2; int t1; int t2; } ment_t;
    typedef struct { int ar; int ai; int iv; int ii; int rv; int ri; int occ; } exp_t;

    ment_t m[$];
    int    mhead = 0;
    exp_t  expq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_n, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, record expected outputs, advance model.
    task automatic cyc(input bit av, input int s1t, input bit s1r, input int s2t, input bit s2r,
                       input bit wbv, input int wbt, input bit ir, input bit cv, input int ci,
                       input bit fl);
        exp_t  e;
        ment_t n;
        int    sel;
        int    ck;
        @(negedge clk);
        alloc_valid = av; alloc_src1_tag = 5'(s1t); alloc_src1_rdy = s1r;
        alloc_src2_tag = 5'(s2t); alloc_src2_rdy = s2r; wb_valid = wbv; wb_tag = 5'(wbt);
        issue_ready = ir; complete_valid = cv; complete_idx = 3'(ci); flush = fl;
        sel = -1;
        foreach (m[k]) if (sel < 0 && m[k].st == RD) sel = k;
        e.occ = m.size();
        e.ar  = (m.size() < 8) ? 1 : 0;
        e.ai  = (mhead + m.size()) % 8;
        e.iv  = (sel >= 0) ? 1 : 0;
        e.ii  = (mhead + ((sel < 0) ? 0 : sel)) % 8;
        e.rv  = (m.size() > 0 && m[0].st == DN) ? 1 : 0;
        e.ri  = mhead;
        expq.push_back(e);
        cyc_n++;
        if (fl) begin
            m.delete();
            mhead = 0;
            return;
        end
        ck = -1;
        if (cv) foreach (m[k]) if ((mhead + k) % 8 == ci && m[k].st == EX) ck = k;
        foreach (m[k]) begin
            if (wbv && m[k].t1 == wbt) m[k].r1 = 1'b1;
            if (wbv && m[k].t2 == wbt) m[k].r2 = 1'b1;
            if (m[k].st == NR && m[k].r1 && m[k].r2) m[k].st = RD;
        end
        if (e.iv == 1 && ir) m[sel].st = EX;
        if (ck >= 0) m[ck].st = DN;
        if (e.rv == 1) begin
            void'(m.pop_front());
            mhead = (mhead + 1) % 8;
        end
        if (av && e.ar == 1) begin
            n.t1 = s1t; n.t2 = s2t;
            n.r1 = s1r || s1t == 0 || (wbv && wbt == s1t);
            n.r2 = s2r || s2t == 0 || (wbv && wbt == s2t);
            n.st = (n.r1 && n.r2) ? RD : NR;
            m.push_back(n);
        end
    endtask

    task automatic idle(input bit ir);
        cyc(0, 0, 0, 0, 0, 0, 0, ir, 0, 0, 0);
    endtask

    task automatic alloc(input int s1t, input bit s1r, input int s2t, input bit s2r, input bit ir);
        cyc(1, s1t, s1r, s2t, s2r, 0, 0, ir, 0, 0, 0);
    endtask

    task automatic complete(input int ci, input bit ir);
        cyc(0, 0, 0, 0, 0, 0, 0, ir, 1, ci, 0);
    endtask

    task automatic rnd_cyc(input int flush_pct);
        int ex_slots[$];
        int ci;
        foreach (m[k]) if (m[k].st == EX) ex_slots.push_back((mhead + k) % 8);
        if (ex_slots.size() > 0 && $urandom_range(0, 3) != 0)
            ci = ex_slots[$urandom_range(0, ex_slots.size() - 1)];
        else
            ci = $urandom_range(0, 7);
        cyc($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 9) < 3,
            $urandom_range(0, 7), $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom_range(0, 9) < 7,
            $urandom_range(0, 1) == 1, ci, $urandom_range(0, 99) < flush_pct);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_alloc_ready"},  32'(alloc_ready), 0);
        chk({tag, "_alloc_idx"},    32'(alloc_idx), 0);
        chk({tag, "_issue_valid"},  32'(issue_valid), 0);
        chk({tag, "_issue_idx"},    32'(issue_idx), 0);
        chk({tag, "_retire_valid"}, 32'(retire_valid), 0);
        chk({tag, "_retire_idx"},   32'(retire_idx), 0);
        chk({tag, "_occupancy"},    32'(occupancy), 0);
    endtask

    // Monitor: compares DUT outputs with the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("alloc_ready",  32'(alloc_ready),  e.ar);
                chk("alloc_idx",    32'(alloc_idx),    e.ai);
                chk("occupancy",    32'(occupancy),    e.occ);
                chk("issue_valid",  32'(issue_valid),  e.iv);
                if (e.iv == 1) chk("issue_idx", 32'(issue_idx), e.ii);
                chk("retire_valid", 32'(retire_valid), e.rv);
                if (e.rv == 1) chk("retire_idx", 32'(retire_idx), e.ri);
            end
        end
    end

    initial begin
        int guard;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Three ready allocations issue in order.
        for (int i = 0; i < 3; i++) alloc(1, 1, 2, 1, 1);
        for (int i = 0; i < 3; i++) idle(1);
        for (int i = 0; i < 3; i++) complete(i, 1);
        for (int i = 0; i < 3; i++) idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Younger ready entry issues first; writeback wakes the older one.
        alloc(7, 0, 3, 1, 1);
        alloc(4, 1, 5, 1, 1);
        idle(1); idle(1);
        cyc(0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        idle(1); idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Fill, refuse when full, out-of-order completion, in-order retire, wrap.
        for (int i = 0; i < 8; i++) alloc(1, 1, 1, 1, 0);
        alloc(1, 1, 1, 1, 0);
        idle(1); idle(1);
        complete(1, 0);
        idle(0);
        complete(0, 0);
        idle(0); idle(0);
        alloc(2, 1, 2, 1, 0);
        alloc(2, 1, 2, 1, 0);
        idle(0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Tag-zero source is ready at allocation; bogus completion ignored.
        alloc(1, 1, 0, 0, 1);
        alloc(9, 0, 9, 0, 0);
        complete(1, 0);
        idle(0); idle(1);

        // Flush with simultaneous allocation.
        alloc(3, 1, 3, 1, 1);
        alloc(3, 1, 3, 1, 1);
        cyc(1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1);
        idle(0);

        for (int i = 0; i < 1500; i++) rnd_cyc(1);

        // Asynchronous reset mid-stream, away from any clock edge.
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        alloc_valid = 0; wb_valid = 0; issue_ready = 0; complete_valid = 0; flush = 0;
        m.delete();
        mhead = 0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) rnd_cyc(1);
        for (int i = 0; i < 3; i++) idle(0);

        guard = 0;
        while (expq.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        #3;
        if (expq.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d expected=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
